// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for param_sync_fifo: default geometry, width helper,
// status record for monitors/scoreboards and the per-cycle operation kind.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 32;

  // Pointer/count width: one extra bit over the address so full and empty differ.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bundle for param_sync_fifo. The master modport is the
// driver/slave testbench side, the slave modport is the FIFO itself.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
);

  logic                                 flush;
  logic                                 wr_en;
  logic [FIFO_WIDTH-1:0]                data_in;
  logic                                 rd_en;
  logic [FIFO_WIDTH-1:0]                data_out;
  logic                                 rd_valid;
  logic                                 full;
  logic                                 empty;
  logic                                 almost_full;
  logic                                 almost_empty;
  logic [cnt_width(FIFO_DEPTH)-1:0]     count;
  logic                                 overflow;
  logic                                 underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module fifo_ram #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [$clog2(FIFO_DEPTH)-1:0] waddr_i,
  input  logic [FIFO_WIDTH-1:0]         wdata_i,
  input  logic                          re_i,
  input  logic [$clog2(FIFO_DEPTH)-1:0] raddr_i,
  output logic [FIFO_WIDTH-1:0]         rdata_o
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] rdata_q;

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Register the addressed word on an accepted read; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and synchronous flush. Define FIFO_ERR_FLAGS_EN to enable the
// sticky overflow/underflow flags; otherwise those outputs are tied low.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  param_sync_fifo_if.slave bus
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "param_sync_fifo: FIFO_DEPTH must be a power of two >= 4");
  end
  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < FIFO_DEPTH)) begin : g_bad_thresh
    $fatal(1, "param_sync_fifo: need 0 < AE_THRESH < AF_THRESH < FIFO_DEPTH");
  end

  logic [CW-1:0]  wptr_q, rptr_q, count_q, count_d;
  logic           rd_valid_q;
  fifo_status_t   status_q;
  logic           wr_acc, rd_acc;
  fifo_op_e       op;

  // Accept decisions come from the registered status, so a simultaneous
  // read/write at empty or full resolves without any combinational loop.
  always_comb begin
    wr_acc = bus.wr_en && !status_q.full  && !bus.flush;
    rd_acc = bus.rd_en && !status_q.empty && !bus.flush;
    op     = fifo_op_e'({wr_acc, rd_acc});
  end

  // Next occupancy from the accepted operation; flush forces zero.
  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else begin
      unique case (op)
        OP_WR:   count_d = count_q + CW'(1);
        OP_RD:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointers, count and read-valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (bus.flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + CW'(1);
        if (rd_acc) rptr_q <= rptr_q + CW'(1);
      end
    end
  end

  // Registered status flags derived from the next count, plus error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q              <= '0;
      status_q.empty        <= 1'b1;
      status_q.almost_empty <= 1'b1;
    end else begin
      status_q.full         <= (count_d == DEPTH_C);
      status_q.empty        <= (count_d == '0);
      status_q.almost_full  <= (count_d >= AF_C);
      status_q.almost_empty <= (count_d <= AE_C);
`ifdef FIFO_ERR_FLAGS_EN
      if (bus.flush) begin
        status_q.overflow  <= 1'b0;
        status_q.underflow <= 1'b0;
      end else begin
        if (bus.wr_en && status_q.full)  status_q.overflow  <= 1'b1;
        if (bus.rd_en && status_q.empty) status_q.underflow <= 1'b1;
      end
`else
      status_q.overflow  <= 1'b0;
      status_q.underflow <= 1'b0;
`endif
    end
  end

  fifo_ram #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.data_in),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (bus.data_out)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = status_q.full;
  assign bus.empty        = status_q.empty;
  assign bus.almost_full  = status_q.almost_full;
  assign bus.almost_empty = status_q.almost_empty;
  assign bus.overflow     = status_q.overflow;
  assign bus.underflow    = status_q.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed phases plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AF = 28;
  localparam int unsigned AE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  param_sync_fifo #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic         m_rdv, m_ovf, m_udf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_rdv  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all();
    int unsigned sz = mq.size();
    logic e_ovf, e_udf;
`ifdef FIFO_ERR_FLAGS_EN
    e_ovf = m_ovf;
    e_udf = m_udf;
`else
    e_ovf = 1'b0;
    e_udf = 1'b0;
`endif
    check("count",        64'(bus.count),    64'(sz));
    check("full",         64'(bus.full),     64'(sz == D));
    check("empty",        64'(bus.empty),    64'(sz == 0));
    check("almost_full",  64'(bus.almost_full),  64'(sz >= AF));
    check("almost_empty", 64'(bus.almost_empty), 64'(sz <= AE));
    check("rd_valid",     64'(bus.rd_valid), 64'(m_rdv));
    check("data_out",     64'(bus.data_out), 64'(m_dout));
    check("overflow",     64'(bus.overflow), 64'(e_ovf));
    check("underflow",    64'(bus.underflow), 64'(e_udf));
  endtask

  // One clock of stimulus, then advance the model and compare.
  task automatic step(input logic w, input logic r, input logic f, input logic [W-1:0] d);
    int unsigned sz;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.data_in = d;
    sz = mq.size();
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      m_rdv = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && sz == D) m_ovf = 1'b1;
      if (r && sz == 0) m_udf = 1'b1;
      m_rdv = r && (sz > 0);
      if (m_rdv) m_dout = mq.pop_front();
      if (w && sz < D) mq.push_back(d);
    end
    check_all();
  endtask

  task automatic fill_to(input int unsigned n);
    while (mq.size() < n) step(1'b1, 1'b0, 1'b0, W'($urandom));
  endtask

  task automatic drain_to(input int unsigned n);
    while (mq.size() > n) step(1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.data_in = '0;
    model_reset();

    // Reset values
    rst = 1'b1;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Write 1..32 (full at the 32nd), then read them back in order
    for (int i = 1; i <= 32; i++) step(1'b1, 1'b0, 1'b0, W'(i));
    check("full_after_32", 64'(bus.full), 64'd1);
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check("read_order", 64'(bus.data_out), 64'(i));
    end
    check("empty_after_32", 64'(bus.empty), 64'd1);

    // Threshold boundaries: 27/28 and 5/4
    fill_to(27);
    fill_to(28);
    drain_to(5);
    drain_to(4);

    // Simultaneous read/write at count 0, 32 and 10
    drain_to(0);
    step(1'b1, 1'b1, 1'b0, W'($urandom));
    fill_to(32);
    step(1'b1, 1'b1, 1'b0, W'($urandom));
    drain_to(10);
    step(1'b1, 1'b1, 1'b0, W'($urandom));
    drain_to(0);

    // Continuous streaming at count 16: pointers wrap several times
    fill_to(16);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, W'($urandom));
    drain_to(0);

    // Flush with concurrent requests at count 12, right after a read
    fill_to(13);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, W'($urandom));

    // Error flags: write when full, read when empty, then flush
    fill_to(32);
    step(1'b1, 1'b0, 1'b0, W'($urandom));
    step(1'b0, 1'b0, 1'b0, '0);
    drain_to(0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 3) != 0), 1'(($urandom % 3) != 0),
           1'(($urandom % 40) == 0), W'($urandom));

    // Asynchronous reset between edges at count 20
    drain_to(0);
    fill_to(20);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1'b0, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, W'(32'h5A5A_0001));
    check("first_write_after_rst", 64'(bus.count), 64'd1);
    step(1'b0, 1'b1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
